// File: rtl/xilinx_distram_pkg.sv
// Shared sizing helpers for the distributed-RAM FIFO family.
//   depth(aw)       : number of RAM words for an address width
//   count_width(aw) : bits needed to hold an occupancy of 0..depth(aw)
package xilinx_distram_pkg;

  function automatic int unsigned depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic int unsigned count_width(input int unsigned aw);
    return $clog2(depth(aw)) + 1;
  endfunction

endpackage

// File: rtl/xilinx_distram_fifo_fwft_if.sv
// Producer/consumer bundle for the FWFT distributed-RAM FIFO.
//   WE, DIN                 : write request and data (from producer)
//   RE                      : pop/acknowledge of the current DOUT (from consumer)
//   DOUT, EMPTY             : head word and its (inverted) valid flag
//   FULL, ALMOST_FULL, COUNT: occupancy status
//   OVERFLOW, UNDERFLOW     : one-cycle error pulses
// master: the user side driving WE/DIN/RE; slave: the FIFO.
interface xilinx_distram_fifo_fwft_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  WE;
  logic [DATA_WIDTH-1:0] DIN;
  logic                  FULL;
  logic                  ALMOST_FULL;
  logic                  RE;
  logic [DATA_WIDTH-1:0] DOUT;
  logic                  EMPTY;
  logic [ADDR_WIDTH:0]   COUNT;
  logic                  OVERFLOW;
  logic                  UNDERFLOW;

  modport master (
    output WE, DIN, RE,
    input  FULL, ALMOST_FULL, DOUT, EMPTY, COUNT, OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  WE, DIN, RE,
    output FULL, ALMOST_FULL, DOUT, EMPTY, COUNT, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/xilinx_sdpdistram_async.sv
// Simple-dual-port distributed LUT RAM, written behaviourally so synthesis maps it onto
// RAMxxX1D primitives. Contents are not reset.
//   WCLK : write clock
//   WE   : write enable
//   WA   : write address
//   D    : write data
//   RA   : read address (asynchronous read)
//   O    : read data, combinationally follows RA
module xilinx_sdpdistram_async #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  WCLK,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] WA,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [ADDR_WIDTH-1:0] RA,
  output logic [DATA_WIDTH-1:0] O
);

  localparam int unsigned Depth = 32'd1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  always_ff @(posedge WCLK) begin
    if (WE) begin
      mem_q[WA] <= D;
    end
  end

  assign O = mem_q[RA];

endmodule

// File: rtl/xilinx_distram_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO built on a distributed LUT RAM with a registered
// output stage. The head word always sits in dout_q; EMPTY is simply !out_valid_q.
//   CLK     : clock, all state updates on the rising edge
//   RST     : synchronous active-high reset
//   fifo_io : slave side of the FIFO bundle (WE/DIN/RE in; DOUT/EMPTY/FULL/ALMOST_FULL/
//             COUNT/OVERFLOW/UNDERFLOW out)
// Occupancy COUNT covers both the RAM (mem_count_q) and the output register.
module xilinx_distram_fifo_fwft
  import xilinx_distram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH         = 5,
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned ALMOST_FULL_THRESH = (32'd1 << ADDR_WIDTH) - 2
) (
  input logic                      CLK,
  input logic                      RST,
  xilinx_distram_fifo_fwft_if.slave fifo_io
);

  localparam int unsigned Depth = depth(ADDR_WIDTH);
  localparam int unsigned CntW  = count_width(ADDR_WIDTH);

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [CntW-1:0]       cnt_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  cnt_t  mem_count_q, mem_count_d;
  cnt_t  count_q, count_d;
  logic  out_valid_q, out_valid_d;
  data_t dout_q, dout_d;
  logic  full_q, full_d;
  logic  almost_full_q, almost_full_d;
  logic  overflow_q, overflow_d;
  logic  underflow_q, underflow_d;

  logic  push, pop, slot_free;
  logic  ram_we;
  data_t ram_rdata;

  xilinx_sdpdistram_async #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .WCLK(CLK),
    .WE  (ram_we && !RST),
    .WA  (wr_ptr_q),
    .D   (fifo_io.DIN),
    .RA  (rd_ptr_q),
    .O   (ram_rdata)
  );

  always_comb begin
    push      = fifo_io.WE && !full_q;
    pop       = fifo_io.RE && out_valid_q;
    // The output register can take a new word if it is empty or being consumed now.
    slot_free = !out_valid_q || pop;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    ram_we      = 1'b0;

    if (slot_free && (mem_count_q != '0)) begin
      // Refill from RAM; a concurrent push lands behind the remaining RAM words.
      dout_d      = ram_rdata;
      rd_ptr_d    = rd_ptr_q + ptr_t'(1);
      out_valid_d = 1'b1;
      if (push) begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end else begin
        mem_count_d = mem_count_q - cnt_t'(1);
      end
    end else if (slot_free && push) begin
      // RAM empty: bypass straight into the output register.
      dout_d      = fifo_io.DIN;
      out_valid_d = 1'b1;
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end else if (push) begin
      ram_we      = 1'b1;
      wr_ptr_d    = wr_ptr_q + ptr_t'(1);
      mem_count_d = mem_count_q + cnt_t'(1);
    end

    count_d       = count_q + cnt_t'(push) - cnt_t'(pop);
    full_d        = (count_d == cnt_t'(Depth));
    almost_full_d = (count_d >= cnt_t'(ALMOST_FULL_THRESH));
    overflow_d    = fifo_io.WE && full_q;
    underflow_d   = fifo_io.RE && !out_valid_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_count_q   <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      dout_q        <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_count_q   <= mem_count_d;
      count_q       <= count_d;
      out_valid_q   <= out_valid_d;
      dout_q        <= dout_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  assign fifo_io.DOUT        = dout_q;
  assign fifo_io.EMPTY       = !out_valid_q;
  assign fifo_io.FULL        = full_q;
  assign fifo_io.ALMOST_FULL = almost_full_q;
  assign fifo_io.COUNT       = count_q;
  assign fifo_io.OVERFLOW    = overflow_q;
  assign fifo_io.UNDERFLOW   = underflow_q;

endmodule

// File: tb/tb_xilinx_distram_fifo_fwft.sv
// Scoreboard bench for xilinx_distram_fifo_fwft (ADDR_WIDTH=5, DATA_WIDTH=8).
// Inputs change on the falling edge; accepted writes are queued as expected data and a
// monitor pops the queue whenever the DUT consumes a word (RE && !EMPTY at the rising edge).
module tb_xilinx_distram_fifo_fwft;

  localparam int unsigned Aw    = 5;
  localparam int unsigned Dw    = 8;
  localparam int          Depth = 32;
  localparam int          AfTh  = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  xilinx_distram_fifo_fwft_if #(.ADDR_WIDTH(Aw), .DATA_WIDTH(Dw)) bus ();

  xilinx_distram_fifo_fwft #(
    .ADDR_WIDTH        (Aw),
    .DATA_WIDTH        (Dw),
    .ALMOST_FULL_THRESH(AfTh)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .fifo_io(bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         mdl_count = 0;
  logic       exp_ovf = 1'b0;
  logic       exp_unf = 1'b0;
  logic [7:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every word the consumer takes must be the oldest word written.
  always @(posedge clk) begin
    if (!rst && bus.RE && !bus.EMPTY) begin
      if (exp_q.size() == 0) begin
        chk("pop_with_empty_scoreboard", 32'(bus.DOUT), 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("dout_pop", 32'(bus.DOUT), 32'(mon_exp));
      end
    end
  end

  task automatic check_state();
    chk("count",       32'(bus.COUNT),       32'(mdl_count));
    chk("empty",       32'(bus.EMPTY),       32'(mdl_count == 0));
    chk("full",        32'(bus.FULL),        32'(mdl_count == Depth));
    chk("almost_full", 32'(bus.ALMOST_FULL), 32'(mdl_count >= AfTh));
    chk("overflow",    32'(bus.OVERFLOW),    32'(exp_ovf));
    chk("underflow",   32'(bus.UNDERFLOW),   32'(exp_unf));
  endtask

  task automatic cycle(input logic we, input logic [7:0] din, input logic re);
    int pu;
    int po;
    @(negedge clk);
    bus.WE  = we;
    bus.DIN = din;
    bus.RE  = re;
    pu = (we && mdl_count < Depth) ? 1 : 0;
    po = (re && mdl_count > 0) ? 1 : 0;
    exp_ovf = we && (mdl_count == Depth);
    exp_unf = re && (mdl_count == 0);
    if (pu != 0) exp_q.push_back(din);
    mdl_count = mdl_count + pu - po;
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset(input logic we);
    @(negedge clk);
    rst     = 1'b1;
    bus.WE  = we;
    bus.DIN = 8'h77;
    bus.RE  = 1'b0;
    exp_q.delete();
    mdl_count = 0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    @(posedge clk);
    #1;
    check_state();
    chk("reset_dout", 32'(bus.DOUT), 32'h0);
    @(negedge clk);
    rst    = 1'b0;
    bus.WE = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * Depth && mdl_count > 0; k++) cycle(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    bus.WE  = 1'b0;
    bus.DIN = '0;
    bus.RE  = 1'b0;

    // Reset then idle, single underflow pulse.
    do_reset(1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("idle_dout", 32'(bus.DOUT), 32'h0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Single write into empty FIFO falls through next cycle.
    cycle(1'b1, 8'hA5, 1'b0);
    chk("a5_dout", 32'(bus.DOUT), 32'hA5);
    cycle(1'b0, 8'h00, 1'b1);

    // Fill, overflow (also with RE asserted), then drain with no bubbles.
    for (int i = 0; i < Depth; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'hEE, 1'b0);
    cycle(1'b1, 8'hEF, 1'b1);
    drain();
    cycle(1'b0, 8'h00, 1'b0);

    // Push+pop at COUNT=1: new word replaces DOUT via bypass.
    cycle(1'b1, 8'h11, 1'b0);
    chk("c1_dout_before", 32'(bus.DOUT), 32'h11);
    cycle(1'b1, 8'h22, 1'b1);
    chk("c1_dout_after", 32'(bus.DOUT), 32'h22);
    cycle(1'b0, 8'h00, 1'b1);

    // Random traffic, write-biased so the pointers wrap several times.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 99) < 70), 8'($urandom), ($urandom_range(0, 99) < 60));
    end
    drain();

    // Reset at COUNT=17 with WE high discards everything.
    for (int i = 0; i < 17; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
    chk("pre_reset_count", 32'(bus.COUNT), 32'd17);
    do_reset(1'b1);
    cycle(1'b1, 8'h5A, 1'b0);
    chk("post_reset_dout", 32'(bus.DOUT), 32'h5A);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
